// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one external memory / L2 block port between the instruction cache
// (port I) and the data cache (port D). One 128-bit block transaction is in
// flight at a time. Contention is resolved round-robin. The winner's request
// is latched, driven to memory until mem_ready, and answered with a
// registered single-cycle ready pulse plus held read data.
//
// Ports
//   clk, proc_reset             system clock, synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata   I-port request (level, held until i_ready)
//   i_rdata, i_ready            I-port read data (held) and completion pulse
//   d_*                         same set for port D
//   mem_read/mem_write          memory strobes
//   mem_addr/mem_wdata          memory block address and write data
//   mem_rdata, mem_ready        memory read data and one-cycle completion
//
// State table
//   state | meaning
//   IDLE  | no transaction; arbitrate between pending requests
//   BUSY  | latched transaction driven to memory, waiting for mem_ready
//   DONE  | winner's ready pulse is high; requests ignored this cycle
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W      = 28,
   parameter int DATA_W      = 128,
   parameter int FIRST_GRANT = 0
) (
   input  logic              clk,
   input  logic              proc_reset,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // 1 = port D favoured on the first contention after reset
   localparam logic LP_FIRST_D = (FIRST_GRANT != 0);

   state_t            r_state;
   logic              r_last_grant;   // 0 = I, 1 = D
   logic              r_win_d;        // winner of the transaction in flight
   logic              r_op_wr;        // latched op: 1 = write, 0 = read
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              r_mem_read;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_i_ready;
   logic              r_d_ready;

   logic              w_i_req;
   logic              w_d_req;
   logic              w_grant_d;
   logic              w_sel_wr;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   assign w_i_req = i_read | i_write;
   assign w_d_req = d_read | d_write;

   // Under contention the port that did not win last time goes next.
   always_comb begin
      w_grant_d = 1'b0;
      if (w_i_req && w_d_req) begin
         w_grant_d = ~r_last_grant;
      end else begin
         w_grant_d = w_d_req;
      end
   end

   // Write dominates when a port raises read and write together.
   always_comb begin
      w_sel_wr    = i_write;
      w_sel_addr  = i_addr;
      w_sel_wdata = i_wdata;
      if (w_grant_d) begin
         w_sel_wr    = d_write;
         w_sel_addr  = d_addr;
         w_sel_wdata = d_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         r_state      <= IDLE;
         r_last_grant <= ~LP_FIRST_D;
         r_win_d      <= 1'b0;
         r_op_wr      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
         r_i_ready    <= 1'b0;
         r_d_ready    <= 1'b0;
      end else begin
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_i_req || w_d_req) begin
                  r_win_d      <= w_grant_d;
                  r_last_grant <= w_grant_d;
                  r_op_wr      <= w_sel_wr;
                  r_addr       <= w_sel_addr;
                  r_wdata      <= w_sel_wdata;
                  r_mem_read   <= ~w_sel_wr;
                  r_mem_write  <= w_sel_wr;
                  r_mem_addr   <= w_sel_addr;
                  r_mem_wdata  <= w_sel_wdata;
                  r_state      <= BUSY;
               end
            end

            BUSY: begin
               if (mem_ready) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  if (!r_op_wr) begin
                     if (r_win_d) begin
                        r_d_rdata <= mem_rdata;
                     end else begin
                        r_i_rdata <= mem_rdata;
                     end
                  end
                  if (r_win_d) begin
                     r_d_ready <= 1'b1;
                  end else begin
                     r_i_ready <= 1'b1;
                  end
                  r_state <= DONE;
               end else begin
                  // Memory sees the latched transaction, never the live inputs.
                  r_mem_read  <= ~r_op_wr;
                  r_mem_write <= r_op_wr;
                  r_mem_addr  <= r_addr;
                  r_mem_wdata <= r_wdata;
               end
            end

            // Caches still hold their strobe while ready is high, so no
            // arbitration here or the same request would be granted twice.
            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign i_ready   = r_i_ready;
   assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int FG = 0;

   logic          clk;
   logic          proc_reset;
   logic          p_rd    [2];
   logic          p_wr    [2];
   logic [AW-1:0] p_addr  [2];
   logic [DW-1:0] p_wdata [2];
   logic [DW-1:0] i_rdata, d_rdata;
   logic          i_ready, d_ready;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready;
   logic          rdy_obs [2];

   assign rdy_obs[0] = i_ready;
   assign rdy_obs[1] = d_ready;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIRST_GRANT(FG)) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .i_read     (p_rd[0]),
      .i_write    (p_wr[0]),
      .i_addr     (p_addr[0]),
      .i_wdata    (p_wdata[0]),
      .i_rdata    (i_rdata),
      .i_ready    (i_ready),
      .d_read     (p_rd[1]),
      .d_write    (p_wr[1]),
      .d_addr     (p_addr[1]),
      .d_wdata    (p_wdata[1]),
      .d_rdata    (d_rdata),
      .d_ready    (d_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp;
   int n_err;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      bit            wr;
      int            port;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t          m_cur;
   bit            m_busy;       // a transaction owns the memory port
   int            m_done_port;  // port whose ready pulse is showing, -1 none
   bit            m_last;       // port granted most recently
   logic [DW-1:0] m_rdata [2];

   logic          e_mem_rd, e_mem_wr;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;
   logic          e_rdy [2];

   task automatic model_step();
      bit req [2];
      int w;
      if (proc_reset) begin
         m_busy      = 0;
         m_done_port = -1;
         m_last      = (FG == 0);
         m_rdata[0]  = '0;
         m_rdata[1]  = '0;
      end else if (m_done_port >= 0) begin
         m_done_port = -1;
      end else if (m_busy) begin
         if (mem_ready) begin
            if (!m_cur.wr) m_rdata[m_cur.port] = mem_rdata;
            m_done_port = m_cur.port;
            m_busy      = 0;
         end
      end else begin
         req[0] = p_rd[0] | p_wr[0];
         req[1] = p_rd[1] | p_wr[1];
         if (req[0] || req[1]) begin
            if (req[0] && req[1]) w = m_last ? 0 : 1;
            else                  w = req[1] ? 1 : 0;
            m_cur.port  = w;
            m_cur.wr    = p_wr[w];
            m_cur.addr  = p_addr[w];
            m_cur.wdata = p_wdata[w];
            m_busy      = 1;
            m_last      = (w == 1);
         end
      end
      e_mem_rd = m_busy && !m_cur.wr;
      e_mem_wr = m_busy && m_cur.wr;
      e_addr   = m_busy ? m_cur.addr  : '0;
      e_wdata  = m_busy ? m_cur.wdata : '0;
      e_rdy[0] = (m_done_port == 0);
      e_rdy[1] = (m_done_port == 1);
   endtask

   // ---------------- memory responder ----------------
   int mem_lat, mem_cnt;
   bit mem_rand_lat, mem_rand_data, mem_spur, mem_kick;

   task automatic drive_mem();
      if (mem_rand_data) mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (mem_read === 1'b1 || mem_write === 1'b1) begin
         if (mem_cnt == mem_lat) begin
            mem_ready = 1'b1;
            mem_cnt   = 0;
            if (mem_rand_lat) mem_lat = int'($urandom_range(0, 4));
         end else begin
            mem_ready = 1'b0;
            mem_cnt++;
         end
      end else begin
         mem_cnt   = 0;
         mem_ready = mem_kick || (mem_spur && ($urandom_range(0, 7) == 0));
      end
   endtask

   bit saw_rd, saw_wr;

   // One clock: inputs already set at a falling edge, sample at the next one.
   task automatic tick();
      drive_mem();
      model_step();
      @(negedge clk);
      if (mem_read === 1'b1)  saw_rd = 1;
      if (mem_write === 1'b1) saw_wr = 1;
      chk("mem_read",  DW'(mem_read),  DW'(e_mem_rd));
      chk("mem_write", DW'(mem_write), DW'(e_mem_wr));
      chk("mem_addr",  DW'(mem_addr),  DW'(e_addr));
      chk("mem_wdata", mem_wdata,      e_wdata);
      chk("i_ready",   DW'(i_ready),   DW'(e_rdy[0]));
      chk("d_ready",   DW'(d_ready),   DW'(e_rdy[1]));
      chk("i_rdata",   i_rdata,        m_rdata[0]);
      chk("d_rdata",   d_rdata,        m_rdata[1]);
   endtask

   task automatic do_reset();
      proc_reset = 1'b1;
      tick();
      proc_reset = 1'b0;
   endtask

   task automatic wait_rdy(input int p, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (rdy_obs[p] !== 1'b1 && n < budget);
      chk($sformatf("ready_seen_p%0d", p), DW'(rdy_obs[p]), DW'(1'b1));
   endtask

   task automatic idle_ports();
      for (int p = 0; p < 2; p++) begin
         p_rd[p] = 1'b0;
         p_wr[p] = 1'b0;
      end
   endtask

   bit out_p [2];

   task automatic drive_ports();
      for (int p = 0; p < 2; p++) begin
         if (out_p[p] && rdy_obs[p] === 1'b1) begin
            out_p[p] = 0;
            p_rd[p]  = 1'b0;
            p_wr[p]  = 1'b0;
         end
         if (!out_p[p] && $urandom_range(0, 2) == 0) begin
            int k;
            k          = int'($urandom_range(0, 7));
            p_rd[p]    = (k < 5) || (k == 7);
            p_wr[p]    = (k >= 5);
            p_addr[p]  = AW'($urandom());
            p_wdata[p] = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_p[p]   = 1;
         end else if (out_p[p] && $urandom_range(0, 9) == 0) begin
            // live inputs wander; only the value at grant time may reach memory
            p_addr[p]  = AW'($urandom());
            p_wdata[p] = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
      end
   endtask

   logic [AW-1:0] grants [$];
   logic [AW-1:0] exp_g;
   bit            prev_strobe;
   int            n_wait;

   initial begin
      n_cmp = 0;
      n_err = 0;
      proc_reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
         p_rd[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; out_p[p] = 0;
      end
      mem_ready = 1'b0; mem_rdata = '0;
      mem_lat = 0; mem_cnt = 0;
      mem_rand_lat = 0; mem_rand_data = 0; mem_spur = 0; mem_kick = 0;
      m_busy = 0; m_done_port = -1; m_last = 1;
      saw_rd = 0; saw_wr = 0;

      tick();
      do_reset();

      // single I read, memory latency 4, then DONE masking of held i_read
      mem_rdata = {16{8'hA5}};
      mem_lat   = 4;
      p_rd[0]   = 1'b1;
      p_addr[0] = 28'h0000123;
      tick();
      chk("t1_strobe", DW'(mem_read), DW'(1'b1));
      chk("t1_addr",   DW'(mem_addr), DW'(28'h0000123));
      wait_rdy(0, 20, n_wait);
      // strobe in cycle 1, mem_ready in cycle 5, i_ready in cycle 6
      chk("t1_latency", DW'(n_wait + 1), DW'(6));
      chk("t1_rdata", i_rdata, {16{8'hA5}});
      tick();
      p_rd[0] = 1'b0;
      tick();
      chk("t4_no_regrant", DW'(mem_read), DW'(1'b0));
      tick();
      chk("t4_no_regrant2", DW'(mem_read), DW'(1'b0));
      chk("t1_rdata_held", i_rdata, {16{8'hA5}});

      // contention from reset: I, D, I, D
      do_reset();
      mem_lat   = 2;
      mem_rdata = {4{32'h5A5A_0F0F}};
      p_addr[0] = 28'h0000111;
      p_addr[1] = 28'h0000222;
      p_rd[0]   = 1'b1;
      p_rd[1]   = 1'b1;
      grants.delete();
      prev_strobe = 0;
      for (int c = 0; c < 80 && grants.size() < 4; c++) begin
         tick();
         if (mem_read === 1'b1 && !prev_strobe) grants.push_back(mem_addr);
         prev_strobe = (mem_read === 1'b1);
      end
      chk("t2_grant_count", DW'(grants.size()), DW'(4));
      for (int g = 0; g < grants.size(); g++) begin
         exp_g = (g % 2 == 0) ? p_addr[0] : p_addr[1];
         chk($sformatf("t2_grant%0d", g), DW'(grants[g]), DW'(exp_g));
      end
      idle_ports();
      repeat (12) tick();

      // D write-back then fill
      do_reset();
      mem_lat    = 1;
      mem_rdata  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      p_wr[1]    = 1'b1;
      p_addr[1]  = 28'h0000010;
      p_wdata[1] = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      saw_rd = 0; saw_wr = 0;
      wait_rdy(1, 20, n_wait);
      chk("t3_wr_seen", DW'(saw_wr), DW'(1'b1));
      chk("t3_no_rd",   DW'(saw_rd), DW'(1'b0));
      chk("t3_rdata_kept", d_rdata, '0);
      p_wr[1]   = 1'b0;
      p_rd[1]   = 1'b1;
      p_addr[1] = 28'h0000020;
      mem_rdata = 128'hCAFE_F00D_0123_4567_89AB_CDEF_CAFE_F00D;
      saw_rd = 0; saw_wr = 0;
      tick();
      chk("t3_done_masked", DW'(mem_read), DW'(1'b0));
      wait_rdy(1, 20, n_wait);
      chk("t3_rd_seen", DW'(saw_rd), DW'(1'b1));
      chk("t3_no_wr",   DW'(saw_wr), DW'(1'b0));
      chk("t3_rdata_fill", d_rdata, 128'hCAFE_F00D_0123_4567_89AB_CDEF_CAFE_F00D);
      p_rd[1] = 1'b0;
      repeat (3) tick();

      // reset while D read is in flight; late mem_ready ignored
      p_rd[1]   = 1'b1;
      p_addr[1] = 28'h0000030;
      mem_lat   = 10;
      mem_rdata = {4{32'h7777_1111}};
      repeat (3) tick();
      chk("t5_busy", DW'(mem_read), DW'(1'b1));
      p_rd[1]    = 1'b0;
      proc_reset = 1'b1;
      tick();
      proc_reset = 1'b0;
      chk("t5_rd_off", DW'(mem_read),  DW'(1'b0));
      chk("t5_wr_off", DW'(mem_write), DW'(1'b0));
      chk("t5_d_rdy",  DW'(d_ready),   DW'(1'b0));
      chk("t5_d_rdata", d_rdata, '0);
      mem_kick = 1;
      tick();
      mem_kick = 0;
      repeat (2) tick();
      chk("t5_late_rdy", DW'(d_ready), DW'(1'b0));
      chk("t5_late_rdata", d_rdata, '0);

      // read and write together on I: write wins
      mem_lat    = 0;
      mem_rdata  = {4{32'h3C3C_A5A5}};
      p_rd[0]    = 1'b1;
      p_wr[0]    = 1'b1;
      p_addr[0]  = 28'h0000040;
      p_wdata[0] = {4{32'h0BAD_F00D}};
      saw_rd = 0; saw_wr = 0;
      wait_rdy(0, 20, n_wait);
      chk("t6_wr_seen", DW'(saw_wr), DW'(1'b1));
      chk("t6_no_rd",   DW'(saw_rd), DW'(1'b0));
      chk("t6_rdata_kept", i_rdata, '0);
      idle_ports();
      repeat (3) tick();

      // randomized traffic with random latency, stray mem_ready and resets
      mem_rand_lat  = 1;
      mem_rand_data = 1;
      mem_spur      = 1;
      mem_lat       = 2;
      for (int c = 0; c < 4000; c++) begin
         drive_ports();
         proc_reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      proc_reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
